// File: rtl/lo_nco.sv
// -----------------------------------------------------------------------------
// lo_nco -- numerically controlled local oscillator
//
// A phase accumulator advanced by a loadable frequency word drives a
// quarter-wave sine ROM. Quadrant folding turns that ROM into full-wave sine and
// cosine outputs. A square-wave LO (the phase MSB) and a valid flag travel
// through the same pipeline, so all four outputs describe the same phase.
//
// Pipeline (every stage advances every cycle):
//   1. phase register
//   2. quadrant decode / address mirror
//   3. synchronous ROM read
//   4. sign apply / output register
//
// Ports
//   clk_in     : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   fre_word   : phase increment, captured when fre_load is high
//   fre_load   : single-cycle strobe, capture fre_word
//   phase_clr  : single-cycle strobe, zero the accumulator (overrides en)
//   en         : accumulator advance enable
//   lo_sin     : signed sine, range +/-(2^(OUT_W-1)-1)
//   lo_cos     : signed cosine, same range
//   lo_sq      : square-wave LO (phase MSB), aligned with lo_sin/lo_cos
//   lo_valid   : outputs derive from a phase produced while en was high
// -----------------------------------------------------------------------------
module lo_nco #(
   parameter int          PHASE_W = 32,
   parameter int          LUT_AW  = 10,
   parameter int          OUT_W   = 12,
   parameter int unsigned FRE_DEF = 324699527
) (
   input  logic                    clk_in,
   input  logic                    rst_n,
   input  logic [PHASE_W-1:0]      fre_word,
   input  logic                    fre_load,
   input  logic                    phase_clr,
   input  logic                    en,
   output logic signed [OUT_W-1:0] lo_sin,
   output logic signed [OUT_W-1:0] lo_cos,
   output logic                    lo_sq,
   output logic                    lo_valid
);

   localparam int  LUT_N = 1 << LUT_AW;
   localparam int  PIPE  = 4;
   localparam real PI    = 3.14159265358979323846;

   // Quarter-wave entry k samples the middle of its phase bin. That offset
   // keeps the mirrored quadrants symmetric and keeps zero out of the table,
   // so the negated half can never reach the most negative code.
   function automatic logic [OUT_W-2:0] lut_entry(input int k);
      real amp;
      real ang;
      int  v;
      amp = real'((1 << (OUT_W-1)) - 1);
      ang = 2.0 * PI * (real'(k) + 0.5) / real'(1 << (LUT_AW+2));
      v   = int'(amp * $sin(ang));
      return v[OUT_W-2:0];
   endfunction

   genvar gi;

   // ---------------------------------------------------------------- stage 1
   logic [PHASE_W-1:0] phase_reg;
   logic [PHASE_W-1:0] fre_reg;

   // The sum uses the increment that was present before this edge. A freshly
   // loaded word therefore counts from the following cycle onward.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         phase_reg <= '0;
         fre_reg   <= PHASE_W'(FRE_DEF);
      end else begin
         if (phase_clr) begin
            phase_reg <= '0;
         end else if (en) begin
            phase_reg <= phase_reg + fre_reg;
         end
         if (fre_load) begin
            fre_reg <= fre_word;
         end
      end
   end

   // ---------------------------------------------------------------- stage 2
   // Cosine is the sine phase advanced by a quarter turn. On the truncated
   // phase, that advance only moves the quadrant by one.
   logic [1:0]        sin_quad;
   logic [1:0]        cos_quad;
   logic [LUT_AW-1:0] phase_idx;

   assign sin_quad  = phase_reg[PHASE_W-1 -: 2];
   assign cos_quad  = sin_quad + 2'd1;
   assign phase_idx = phase_reg[PHASE_W-3 -: LUT_AW];

   logic [LUT_AW-1:0] sin_addr_reg;
   logic [LUT_AW-1:0] cos_addr_reg;
   logic              sin_neg2_reg;
   logic              cos_neg2_reg;
   logic              sq2_reg;

   // Odd quadrants read the table backwards. The upper half-turn is negated.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sin_addr_reg <= '0;
         cos_addr_reg <= '0;
         sin_neg2_reg <= 1'b0;
         cos_neg2_reg <= 1'b0;
         sq2_reg      <= 1'b0;
      end else begin
         sin_addr_reg <= sin_quad[0] ? ~phase_idx : phase_idx;
         cos_addr_reg <= cos_quad[0] ? ~phase_idx : phase_idx;
         sin_neg2_reg <= sin_quad[1];
         cos_neg2_reg <= cos_quad[1];
         sq2_reg      <= phase_reg[PHASE_W-1];
      end
   end

   // ---------------------------------------------------------------- stage 3
   logic [OUT_W-2:0] rom [LUT_N];

   for (gi = 0; gi < LUT_N; gi++) begin : g_rom
      localparam logic [OUT_W-2:0] ENTRY = lut_entry(gi);
      assign rom[gi] = ENTRY;
   end

   logic [OUT_W-2:0] sin_mag_reg;
   logic [OUT_W-2:0] cos_mag_reg;
   logic             sin_neg3_reg;
   logic             cos_neg3_reg;
   logic             sq3_reg;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sin_mag_reg  <= '0;
         cos_mag_reg  <= '0;
         sin_neg3_reg <= 1'b0;
         cos_neg3_reg <= 1'b0;
         sq3_reg      <= 1'b0;
      end else begin
         sin_mag_reg  <= rom[sin_addr_reg];
         cos_mag_reg  <= rom[cos_addr_reg];
         sin_neg3_reg <= sin_neg2_reg;
         cos_neg3_reg <= cos_neg2_reg;
         sq3_reg      <= sq2_reg;
      end
   end

   // ---------------------------------------------------------------- stage 4
   logic signed [OUT_W-1:0] sin_pos;
   logic signed [OUT_W-1:0] cos_pos;

   assign sin_pos = $signed({1'b0, sin_mag_reg});
   assign cos_pos = $signed({1'b0, cos_mag_reg});

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         lo_sin <= '0;
         lo_cos <= '0;
         lo_sq  <= 1'b0;
      end else begin
         lo_sin <= sin_neg3_reg ? -sin_pos : sin_pos;
         lo_cos <= cos_neg3_reg ? -cos_pos : cos_pos;
         lo_sq  <= sq3_reg;
      end
   end

   // ---------------------------------------------------------------- valid
   // en follows the same four stages as the phase. On reset, this shift
   // register is cleared together with the data, so no stale sample can be
   // flagged valid after release.
   logic [PIPE-1:0] vld_reg;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         vld_reg <= '0;
      end else begin
         vld_reg <= {vld_reg[PIPE-2:0], en};
      end
   end

   assign lo_valid = vld_reg[PIPE-1];

endmodule

// File: tb/tb_lo_nco.sv
// -----------------------------------------------------------------------------
// tb_lo_nco -- self-checking bench for lo_nco
//
// The reference model works on the accumulated phase. Each output is computed
// as sin/cos of the centre of the truncated 12-bit phase bin, then delayed by
// the pipeline latency. The bench combines a table of hand-derived vectors,
// hand-written corner sequences, a full quarter-wave-point sweep and
// randomized traffic.
// -----------------------------------------------------------------------------
module tb_lo_nco;

   localparam int          PHASE_W = 32;
   localparam int          LUT_AW  = 10;
   localparam int          OUT_W   = 12;
   localparam logic [31:0] FRE_DEF = 32'd324699527;
   localparam real         PI      = 3.14159265358979323846;

   logic                    clk_in;
   logic                    rst_n;
   logic [PHASE_W-1:0]      fre_word;
   logic                    fre_load;
   logic                    phase_clr;
   logic                    en;
   logic signed [OUT_W-1:0] lo_sin;
   logic signed [OUT_W-1:0] lo_cos;
   logic                    lo_sq;
   logic                    lo_valid;

   lo_nco #(
      .PHASE_W (PHASE_W),
      .LUT_AW  (LUT_AW),
      .OUT_W   (OUT_W),
      .FRE_DEF (324699527)
   ) dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .fre_word  (fre_word),
      .fre_load  (fre_load),
      .phase_clr (phase_clr),
      .en        (en),
      .lo_sin    (lo_sin),
      .lo_cos    (lo_cos),
      .lo_sq     (lo_sq),
      .lo_valid  (lo_valid)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct {
      int s;
      int c;
      bit sq;
      bit v;
      bit known;
   } exp_t;

   typedef struct {
      bit          ld;
      logic [31:0] w;
      bit          clr;
      bit          e;
      bit          chk;
      int          s;
      int          c;
      bit          sq;
      bit          v;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   logic [31:0] m_phase;
   logic [31:0] m_fre;
   exp_t        exp_q [$];

   function automatic exp_t mk(input int s, input int c, input bit sq, input bit v);
      exp_t r;
      r.s = s; r.c = c; r.sq = sq; r.v = v; r.known = 1'b1;
      return r;
   endfunction

   // Output for accumulated phase p: sin/cos at the centre of its 4096-point bin.
   function automatic exp_t ref_out(input logic [31:0] p, input bit v);
      int  t;
      real ang;
      t   = int'(p >> 20);
      ang = 2.0 * PI * (real'(t) + 0.5) / 4096.0;
      return mk(int'(2047.0 * $sin(ang)), int'(2047.0 * $cos(ang)), p[31], v);
   endfunction

   // After reset, the two deepest stages hold reset contents. Only their valid
   // flag is defined. The third value comes from the reset phase of zero.
   task automatic model_reset();
      exp_t u;
      u = '{default: 0};
      m_phase = '0;
      m_fre   = FRE_DEF;
      exp_q.delete();
      exp_q.push_back(u);
      exp_q.push_back(u);
      exp_q.push_back(ref_out(32'h0, 1'b0));
   endtask

   task automatic cmp(input string name, input exp_t x);
      n_tests++;
      if (lo_sin !== OUT_W'(x.s) || lo_cos !== OUT_W'(x.c) ||
          lo_sq !== x.sq || lo_valid !== x.v) begin
         n_fail++;
         $display("FAIL %s cyc %0d: got sin=%0d cos=%0d sq=%b valid=%b, expected sin=%0d cos=%0d sq=%0b valid=%0b",
                  name, cyc, lo_sin, lo_cos, lo_sq, lo_valid, x.s, x.c, x.sq, x.v);
      end else begin
         $display("[TB] ok %s cyc %0d sin=%0d cos=%0d sq=%b valid=%b",
                  name, cyc, lo_sin, lo_cos, lo_sq, lo_valid);
      end
   endtask

   task automatic cmp_valid(input string name, input bit v);
      n_tests++;
      if (lo_valid !== v) begin
         n_fail++;
         $display("FAIL %s cyc %0d: got valid=%b, expected valid=%0b", name, cyc, lo_valid, v);
      end else begin
         $display("[TB] ok %s cyc %0d valid=%b", name, cyc, lo_valid);
      end
   endtask

   // One clock: drive the inputs, step the model at the edge, check 1 ns later.
   task automatic step(input bit ld, input logic [31:0] w, input bit clr, input bit e,
                       input string tag);
      exp_t x;
      fre_load  = ld;
      fre_word  = w;
      phase_clr = clr;
      en        = e;
      @(posedge clk_in);
      if (clr)    m_phase = '0;
      else if (e) m_phase = m_phase + m_fre;
      if (ld)     m_fre = w;
      exp_q.push_back(ref_out(m_phase, e));
      x = exp_q.pop_front();
      #1;
      cyc++;
      if (x.known) cmp(tag, x);
      else         cmp_valid(tag, 1'b0);
   endtask

   // Assert reset immediately (mid-cycle), confirm the outputs clear without a
   // clock edge, hold for ncyc edges, then release.
   task automatic do_reset(input int ncyc, input string tag);
      rst_n     = 1'b0;
      fre_load  = 1'b0;
      phase_clr = 1'b0;
      en        = 1'b0;
      fre_word  = '0;
      #1;
      cmp({tag, "_async"}, mk(0, 0, 1'b0, 1'b0));
      repeat (ncyc) @(posedge clk_in);
      #1;
      cmp({tag, "_held"}, mk(0, 0, 1'b0, 1'b0));
      rst_n = 1'b1;
      model_reset();
   endtask

   vec_t tbl [12];

   initial begin
      int  fall_at;
      bit  done;

      // Steady quarter-turn stepping after reset. The word is loaded while en
      // is still low, so the first enabled sum already uses it.
      tbl[0]  = '{1'b1, 32'h4000_0000, 1'b0, 1'b0, 1'b0,     0,     0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0,     0,     0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1,     2,  2047, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1,     2,  2047, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1,     2,  2047, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1,     2,  2047, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1,  2047,    -2, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1,    -2, -2047, 1'b1, 1'b1};
      tbl[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, -2047,     2, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1,     2,  2047, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1,  2047,    -2, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1,    -2, -2047, 1'b1, 1'b1};

      rst_n     = 1'b1;
      fre_load  = 1'b0;
      fre_word  = '0;
      phase_clr = 1'b0;
      en        = 1'b0;
      m_phase   = '0;
      m_fre     = FRE_DEF;
      #3;
      do_reset(2, "reset");

      // Table vectors
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].ld, tbl[i].w, tbl[i].clr, tbl[i].e, "tbl_model");
         if (tbl[i].chk) cmp($sformatf("tbl_%0d", i), mk(tbl[i].s, tbl[i].c, tbl[i].sq, tbl[i].v));
      end

      // Three-quarter-turn increment: the phase wraps downward each cycle.
      step(1'b1, 32'hC000_0000, 1'b0, 1'b0, "wrap_ld");
      for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b1, "wrap");

      // Enable drop: lo_valid must fall on the 4th edge after en goes low, and
      // the outputs hold at the last phase.
      step(1'b1, 32'h0123_4567, 1'b0, 1'b0, "en_ld");
      for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b1, "en_on");
      fall_at = 0;
      done    = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 32'h0, 1'b0, 1'b0, "en_off");
         if (!done && lo_valid === 1'b0) begin
            fall_at = i;
            done    = 1'b1;
         end
      end
      n_tests++;
      if (fall_at != 4) begin
         n_fail++;
         $display("FAIL valid_fall: got %0d cycles, expected 4", fall_at);
      end else begin
         $display("[TB] ok valid_fall after %0d cycles", fall_at);
      end

      // Clear and load in the same cycle: phase 0 then the new increment.
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b1, "pre_clr");
      step(1'b1, 32'h4000_0000, 1'b1, 1'b1, "clr_ld");
      for (int i = 2; i <= 5; i++) begin
         step(1'b0, 32'h0, 1'b0, 1'b1, "post_clr");
         if (i == 4) cmp("clr_sin_2", mk(2, 2047, 1'b0, 1'b1));
         if (i == 5) cmp("clr_next", mk(2047, -2, 1'b0, 1'b1));
      end

      // Sweep of every quarter-wave phase point
      step(1'b1, 32'h0010_0000, 1'b1, 1'b0, "sweep_ld");
      for (int i = 0; i < 4096 + 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1, "sweep");

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 15) == 0,
              $urandom_range(0, 3) != 0, "rand");
      end

      // Reset pulse while running: clears at once. Afterwards the default
      // increment is in effect again.
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b1, "pre_rst");
      #2;
      do_reset(1, "mid_reset");
      for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b0, 1'b1, "post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
